// File: rtl/csr_reg_pkg.sv
// Shared CSR definitions: widths, machine-mode address map, mstatus write mask
// and the small helpers used to decide which addresses accept writes.
package csr_reg_pkg;

   localparam int CPU_WIDTH      = 32;
   localparam int CSR_ADDR_WIDTH = 12;

   typedef logic [CSR_ADDR_WIDTH-1:0] csr_addr_t;
   typedef logic [CPU_WIDTH-1:0]      csr_data_t;

   localparam csr_addr_t CSR_MSTATUS   = 12'h300;
   localparam csr_addr_t CSR_MISA      = 12'h301;
   localparam csr_addr_t CSR_MIE       = 12'h304;
   localparam csr_addr_t CSR_MTVEC     = 12'h305;
   localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
   localparam csr_addr_t CSR_MEPC      = 12'h341;
   localparam csr_addr_t CSR_MCAUSE    = 12'h342;
   localparam csr_addr_t CSR_MTVAL     = 12'h343;
   localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
   localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
   localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
   localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
   localparam csr_addr_t CSR_CYCLE     = 12'hC00;
   localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
   localparam csr_addr_t CSR_INSTRET   = 12'hC02;
   localparam csr_addr_t CSR_INSTRETH  = 12'hC82;

   localparam csr_data_t MSTATUS_WMASK = 32'h0000_0088;
   // MPP is hard-wired to machine mode
   localparam csr_data_t MSTATUS_FIXED = 32'h0000_1800;

   function automatic logic csr_writable(csr_addr_t a);
      logic w_ok;
      case (a)
         CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
         CSR_MTVAL, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
            w_ok = 1'b1;
         default:
            w_ok = 1'b0;
      endcase
      return w_ok;
   endfunction

   function automatic csr_data_t csr_wval(csr_addr_t a, csr_data_t d);
      return (a == CSR_MSTATUS) ? ((d & MSTATUS_WMASK) | MSTATUS_FIXED) : d;
   endfunction

   function automatic logic port_hit(logic en, csr_addr_t a, csr_addr_t tgt);
      return en && (a == tgt);
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit incrementer with independent low/high write overrides; a write to
// either half suppresses the carry into the high half for that cycle.
module csr_counter64
   import csr_reg_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc_i,
   input  logic        wr_lo_en_i,
   input  csr_data_t   wr_lo_data_i,
   input  logic        wr_hi_en_i,
   input  csr_data_t   wr_hi_data_i,
   output logic [63:0] cnt_o
);

   csr_data_t   r_lo;
   csr_data_t   r_hi;
   logic [32:0] w_lo_sum;

   assign w_lo_sum = {1'b0, r_lo} + {32'd0, inc_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lo <= '0;
         r_hi <= '0;
      end else begin
         r_lo <= wr_lo_en_i ? wr_lo_data_i : w_lo_sum[31:0];
         if (wr_hi_en_i)
            r_hi <= wr_hi_data_i;
         else if (!wr_lo_en_i)
            r_hi <= r_hi + {31'd0, w_lo_sum[32]};
      end
   end

   assign cnt_o = {r_hi, r_lo};

endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR file: WB write port, higher-priority trap write port,
// combinational forwarding read port and the mcycle/minstret counters.
module csr_reg
   import csr_reg_pkg::*;
#(
   parameter csr_data_t MTVEC_RST = 32'h0000_0000,
   parameter csr_data_t MISA_VAL  = 32'h4000_0100
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      csr_wr_en_i,
   input  csr_addr_t csr_wr_adder_i,
   input  csr_data_t csr_wr_data_i,
   input  logic      inst_retire_i,
   input  logic      trap_wr_en_i,
   input  csr_addr_t trap_wr_adder_i,
   input  csr_data_t trap_wr_data_i,
   input  csr_addr_t csr_rd_adder_i,
   output csr_data_t csr_rd_data_o,
   output csr_data_t mtvec_o,
   output csr_data_t mepc_o,
   output csr_data_t mstatus_o,
   output logic      global_int_en_o
);

   csr_data_t   r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
   logic [63:0] w_mcycle, w_minstret;

   logic      w_cyc_lo_we, w_cyc_hi_we, w_ins_lo_we, w_ins_hi_we;
   csr_data_t w_cyc_lo_d, w_cyc_hi_d, w_ins_lo_d, w_ins_hi_d;

   // WB write is applied first so a trap write to the same address overrides it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mstatus  <= MSTATUS_FIXED;
         r_mie      <= '0;
         r_mtvec    <= MTVEC_RST;
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_mtval    <= '0;
      end else begin
         if (csr_wr_en_i) begin
            case (csr_wr_adder_i)
               CSR_MSTATUS:  r_mstatus  <= csr_wval(CSR_MSTATUS, csr_wr_data_i);
               CSR_MIE:      r_mie      <= csr_wr_data_i;
               CSR_MTVEC:    r_mtvec    <= csr_wr_data_i;
               CSR_MSCRATCH: r_mscratch <= csr_wr_data_i;
               CSR_MEPC:     r_mepc     <= csr_wr_data_i;
               CSR_MCAUSE:   r_mcause   <= csr_wr_data_i;
               CSR_MTVAL:    r_mtval    <= csr_wr_data_i;
               default: ;
            endcase
         end
         if (trap_wr_en_i) begin
            case (trap_wr_adder_i)
               CSR_MSTATUS:  r_mstatus  <= csr_wval(CSR_MSTATUS, trap_wr_data_i);
               CSR_MIE:      r_mie      <= trap_wr_data_i;
               CSR_MTVEC:    r_mtvec    <= trap_wr_data_i;
               CSR_MSCRATCH: r_mscratch <= trap_wr_data_i;
               CSR_MEPC:     r_mepc     <= trap_wr_data_i;
               CSR_MCAUSE:   r_mcause   <= trap_wr_data_i;
               CSR_MTVAL:    r_mtval    <= trap_wr_data_i;
               default: ;
            endcase
         end
      end
   end

   assign w_cyc_lo_we = port_hit(trap_wr_en_i, trap_wr_adder_i, CSR_MCYCLE)
                      | port_hit(csr_wr_en_i, csr_wr_adder_i, CSR_MCYCLE);
   assign w_cyc_lo_d  = port_hit(trap_wr_en_i, trap_wr_adder_i, CSR_MCYCLE)
                      ? trap_wr_data_i : csr_wr_data_i;
   assign w_cyc_hi_we = port_hit(trap_wr_en_i, trap_wr_adder_i, CSR_MCYCLEH)
                      | port_hit(csr_wr_en_i, csr_wr_adder_i, CSR_MCYCLEH);
   assign w_cyc_hi_d  = port_hit(trap_wr_en_i, trap_wr_adder_i, CSR_MCYCLEH)
                      ? trap_wr_data_i : csr_wr_data_i;
   assign w_ins_lo_we = port_hit(trap_wr_en_i, trap_wr_adder_i, CSR_MINSTRET)
                      | port_hit(csr_wr_en_i, csr_wr_adder_i, CSR_MINSTRET);
   assign w_ins_lo_d  = port_hit(trap_wr_en_i, trap_wr_adder_i, CSR_MINSTRET)
                      ? trap_wr_data_i : csr_wr_data_i;
   assign w_ins_hi_we = port_hit(trap_wr_en_i, trap_wr_adder_i, CSR_MINSTRETH)
                      | port_hit(csr_wr_en_i, csr_wr_adder_i, CSR_MINSTRETH);
   assign w_ins_hi_d  = port_hit(trap_wr_en_i, trap_wr_adder_i, CSR_MINSTRETH)
                      ? trap_wr_data_i : csr_wr_data_i;

   csr_counter64 u_mcycle (
      .clk          (clk),
      .rst_n        (rst_n),
      .inc_i        (1'b1),
      .wr_lo_en_i   (w_cyc_lo_we),
      .wr_lo_data_i (w_cyc_lo_d),
      .wr_hi_en_i   (w_cyc_hi_we),
      .wr_hi_data_i (w_cyc_hi_d),
      .cnt_o        (w_mcycle)
   );

   csr_counter64 u_minstret (
      .clk          (clk),
      .rst_n        (rst_n),
      .inc_i        (inst_retire_i),
      .wr_lo_en_i   (w_ins_lo_we),
      .wr_lo_data_i (w_ins_lo_d),
      .wr_hi_en_i   (w_ins_hi_we),
      .wr_hi_data_i (w_ins_hi_d),
      .cnt_o        (w_minstret)
   );

   // Only writable addresses forward; read-only aliases see the stored counter
   always_comb begin
      csr_rd_data_o = '0;
      if (csr_writable(csr_rd_adder_i) &&
          port_hit(trap_wr_en_i, trap_wr_adder_i, csr_rd_adder_i)) begin
         csr_rd_data_o = csr_wval(csr_rd_adder_i, trap_wr_data_i);
      end else if (csr_writable(csr_rd_adder_i) &&
                   port_hit(csr_wr_en_i, csr_wr_adder_i, csr_rd_adder_i)) begin
         csr_rd_data_o = csr_wval(csr_rd_adder_i, csr_wr_data_i);
      end else begin
         case (csr_rd_adder_i)
            CSR_MSTATUS:                 csr_rd_data_o = r_mstatus;
            CSR_MISA:                    csr_rd_data_o = MISA_VAL;
            CSR_MIE:                     csr_rd_data_o = r_mie;
            CSR_MTVEC:                   csr_rd_data_o = r_mtvec;
            CSR_MSCRATCH:                csr_rd_data_o = r_mscratch;
            CSR_MEPC:                    csr_rd_data_o = r_mepc;
            CSR_MCAUSE:                  csr_rd_data_o = r_mcause;
            CSR_MTVAL:                   csr_rd_data_o = r_mtval;
            CSR_MCYCLE,   CSR_CYCLE:     csr_rd_data_o = w_mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    csr_rd_data_o = w_mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   csr_rd_data_o = w_minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_rd_data_o = w_minstret[63:32];
            default:                     csr_rd_data_o = '0;
         endcase
      end
   end

   assign mtvec_o         = r_mtvec;
   assign mepc_o          = r_mepc;
   assign mstatus_o       = r_mstatus;
   assign global_int_en_o = r_mstatus[3];

endmodule

// File: tb/tb_csr_reg.sv
// Directed plus random checks of csr_reg against a behavioural model built
// from address-keyed storage and 64-bit counter arithmetic.
module tb_csr_reg;

   localparam logic [31:0] TB_MTVEC_RST = 32'h0000_0100;
   localparam logic [31:0] TB_MISA      = 32'h4000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        csr_wr_en_i;
   logic [11:0] csr_wr_adder_i;
   logic [31:0] csr_wr_data_i;
   logic        inst_retire_i;
   logic        trap_wr_en_i;
   logic [11:0] trap_wr_adder_i;
   logic [31:0] trap_wr_data_i;
   logic [11:0] csr_rd_adder_i;
   logic [31:0] csr_rd_data_o;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;
   logic [31:0] mstatus_o;
   logic        global_int_en_o;

   int checks = 0;
   int errors = 0;

   csr_reg #(.MTVEC_RST(TB_MTVEC_RST), .MISA_VAL(TB_MISA)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .csr_wr_en_i     (csr_wr_en_i),
      .csr_wr_adder_i  (csr_wr_adder_i),
      .csr_wr_data_i   (csr_wr_data_i),
      .inst_retire_i   (inst_retire_i),
      .trap_wr_en_i    (trap_wr_en_i),
      .trap_wr_adder_i (trap_wr_adder_i),
      .trap_wr_data_i  (trap_wr_data_i),
      .csr_rd_adder_i  (csr_rd_adder_i),
      .csr_rd_data_o   (csr_rd_data_o),
      .mtvec_o         (mtvec_o),
      .mepc_o          (mepc_o),
      .mstatus_o       (mstatus_o),
      .global_int_en_o (global_int_en_o)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] m_reg [logic [11:0]];
   logic [63:0] m_cyc;
   logic [63:0] m_ins;

   logic [11:0] pool [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                              12'h341, 12'h342, 12'h343, 12'hB00, 12'hB80,
                              12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                              12'hC82, 12'h7C0, 12'h123, 12'h341, 12'h300};

   function automatic logic m_writable(logic [11:0] a);
      return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                       12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82};
   endfunction

   function automatic logic [31:0] m_wval(logic [11:0] a, logic [31:0] d);
      if (a == 12'h300) return (d & 32'h0000_0088) | 32'h0000_1800;
      return d;
   endfunction

   function automatic logic [31:0] m_read(logic [11:0] a);
      if (trap_wr_en_i && trap_wr_adder_i == a && m_writable(a))
         return m_wval(a, trap_wr_data_i);
      if (csr_wr_en_i && csr_wr_adder_i == a && m_writable(a))
         return m_wval(a, csr_wr_data_i);
      case (a)
         12'h301:          return TB_MISA;
         12'hB00, 12'hC00: return m_cyc[31:0];
         12'hB80, 12'hC80: return m_cyc[63:32];
         12'hB02, 12'hC02: return m_ins[31:0];
         12'hB82, 12'hC82: return m_ins[63:32];
         default:          return m_reg.exists(a) ? m_reg[a] : 32'h0;
      endcase
   endfunction

   function automatic logic [63:0] m_cnt_next(logic [63:0] c, logic inc,
         logic lo_w, logic [31:0] lo_d, logic hi_w, logic [31:0] hi_d);
      logic [31:0] lo;
      logic [31:0] hi;
      if (!lo_w && !hi_w) return c + {63'd0, inc};
      lo = lo_w ? lo_d : c[31:0] + {31'd0, inc};
      hi = hi_w ? hi_d : c[63:32];
      return {hi, lo};
   endfunction

   task automatic m_reset();
      m_reg.delete();
      m_reg[12'h300] = 32'h0000_1800;
      m_reg[12'h304] = 32'h0;
      m_reg[12'h305] = TB_MTVEC_RST;
      m_reg[12'h340] = 32'h0;
      m_reg[12'h341] = 32'h0;
      m_reg[12'h342] = 32'h0;
      m_reg[12'h343] = 32'h0;
      m_cyc = 64'd0;
      m_ins = 64'd0;
   endtask

   task automatic m_commit();
      logic [31:0] eff [logic [11:0]];
      if (csr_wr_en_i && m_writable(csr_wr_adder_i))
         eff[csr_wr_adder_i] = m_wval(csr_wr_adder_i, csr_wr_data_i);
      if (trap_wr_en_i && m_writable(trap_wr_adder_i))
         eff[trap_wr_adder_i] = m_wval(trap_wr_adder_i, trap_wr_data_i);
      foreach (eff[k]) if (m_reg.exists(k)) m_reg[k] = eff[k];
      m_cyc = m_cnt_next(m_cyc, 1'b1,
                         eff.exists(12'hB00), eff.exists(12'hB00) ? eff[12'hB00] : 32'h0,
                         eff.exists(12'hB80), eff.exists(12'hB80) ? eff[12'hB80] : 32'h0);
      m_ins = m_cnt_next(m_ins, inst_retire_i,
                         eff.exists(12'hB02), eff.exists(12'hB02) ? eff[12'hB02] : 32'h0,
                         eff.exists(12'hB82), eff.exists(12'hB82) ? eff[12'hB82] : 32'h0);
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(string tag);
      logic [31:0] ms;
      ms = m_reg[12'h300];
      chk({tag, " mstatus_o"}, mstatus_o, ms);
      chk({tag, " mtvec_o"}, mtvec_o, m_reg[12'h305]);
      chk({tag, " mepc_o"}, mepc_o, m_reg[12'h341]);
      chk({tag, " global_int_en_o"}, {31'd0, global_int_en_o}, {31'd0, ms[3]});
   endtask

   // Combinational read check, one clock, then output check after the edge.
   task automatic cycle(string tag);
      #1;
      chk({tag, " rd"}, csr_rd_data_o, m_read(csr_rd_adder_i));
      @(posedge clk);
      m_commit();
      @(negedge clk);
      chk_outputs(tag);
   endtask

   task automatic peek(string tag, logic [11:0] a, logic [31:0] exp);
      csr_rd_adder_i = a;
      #1;
      chk(tag, csr_rd_data_o, exp);
      chk({tag, " model"}, csr_rd_data_o, m_read(a));
   endtask

   task automatic idle();
      csr_wr_en_i    = 1'b0;
      trap_wr_en_i   = 1'b0;
      inst_retire_i  = 1'b0;
      csr_wr_adder_i = 12'h0;
      csr_wr_data_i  = 32'h0;
      trap_wr_adder_i = 12'h0;
      trap_wr_data_i = 32'h0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      csr_rd_adder_i = 12'hB00;
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // reset state and free-running mcycle
      chk_outputs("reset");
      for (int i = 0; i < 10; i++) cycle("count");
      peek("mcycle after 10", 12'hB00, 32'd10);
      peek("mcycleh after 10", 12'hB80, 32'd0);
      chk("reset mstatus", mstatus_o, 32'h0000_1800);
      chk("reset mtvec", mtvec_o, TB_MTVEC_RST);

      // mstatus write mask and forwarding
      csr_wr_en_i = 1'b1; csr_wr_adder_i = 12'h300; csr_wr_data_i = 32'hFFFF_FFFF;
      peek("mstatus fwd", 12'h300, 32'h0000_1888);
      cycle("mstatus wr");
      idle();
      chk("mstatus masked", mstatus_o, 32'h0000_1888);
      chk("gie set", {31'd0, global_int_en_o}, 32'd1);

      // trap port wins on collision; distinct addresses both commit
      csr_wr_en_i = 1'b1; csr_wr_adder_i = 12'h341; csr_wr_data_i = 32'h100;
      trap_wr_en_i = 1'b1; trap_wr_adder_i = 12'h341; trap_wr_data_i = 32'h200;
      peek("mepc fwd trap", 12'h341, 32'h200);
      cycle("mepc collide");
      chk("mepc trap wins", mepc_o, 32'h200);
      csr_wr_adder_i = 12'h305; csr_wr_data_i = 32'h80;
      trap_wr_adder_i = 12'h342; trap_wr_data_i = 32'h8000_000B;
      cycle("dual write");
      idle();
      chk("mtvec wb", mtvec_o, 32'h80);
      peek("mcause trap", 12'h342, 32'h8000_000B);

      // mcycle carry across halves
      csr_wr_en_i = 1'b1; csr_wr_adder_i = 12'hB00; csr_wr_data_i = 32'hFFFF_FFFE;
      trap_wr_en_i = 1'b1; trap_wr_adder_i = 12'hB80; trap_wr_data_i = 32'h0;
      cycle("mcycle wr");
      idle();
      csr_rd_adder_i = 12'hB00;
      cycle("mcycle run1");
      cycle("mcycle run2");
      peek("mcycle wrapped", 12'hB00, 32'd0);
      peek("mcycleh carry", 12'hB80, 32'd1);
      peek("cycleh alias", 12'hC80, 32'd1);

      // minstret write overrides increment
      csr_rd_adder_i = 12'hB02;
      for (int i = 0; i < 5; i++) begin
         idle();
         inst_retire_i = 1'b1;
         if (i == 2) begin
            csr_wr_en_i = 1'b1; csr_wr_adder_i = 12'hB02; csr_wr_data_i = 32'h10;
         end
         cycle("retire");
      end
      idle();
      peek("minstret", 12'hB02, 32'h12);
      csr_wr_en_i = 1'b1; csr_wr_adder_i = 12'hC02; csr_wr_data_i = 32'hDEAD_BEEF;
      peek("instret no fwd", 12'hC02, 32'h12);
      cycle("ro write");
      idle();
      peek("minstret kept", 12'hB02, 32'h12);
      peek("unmapped", 12'h7C0, 32'h0);
      peek("misa", 12'h301, TB_MISA);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         csr_wr_en_i     = $urandom_range(0, 1) == 1;
         csr_wr_adder_i  = pool[$urandom_range(0, 19)];
         csr_wr_data_i   = $urandom;
         trap_wr_en_i    = $urandom_range(0, 3) == 0;
         trap_wr_adder_i = ($urandom_range(0, 3) == 0) ? csr_wr_adder_i
                                                       : pool[$urandom_range(0, 19)];
         trap_wr_data_i  = $urandom;
         inst_retire_i   = $urandom_range(0, 1) == 1;
         case ($urandom_range(0, 2))
            0:       csr_rd_adder_i = csr_wr_adder_i;
            1:       csr_rd_adder_i = trap_wr_adder_i;
            default: csr_rd_adder_i = pool[$urandom_range(0, 19)];
         endcase
         cycle("random");
      end
      idle();

      // asynchronous reset between clock edges
      csr_wr_en_i = 1'b1; csr_wr_adder_i = 12'h341; csr_wr_data_i = 32'h1234;
      csr_rd_adder_i = 12'hB00;
      #2;
      rst_n = 1'b0;
      m_reset();
      idle();
      #1;
      chk_outputs("async rst");
      chk("async rst mcycle", csr_rd_data_o, 32'd0);
      @(negedge clk);
      chk_outputs("held rst");
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cycle("restart");
      peek("mcycle restart", 12'hB00, 32'd4);
      peek("minstret restart", 12'hB02, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_reg.md
Name: csr_reg

Overview:
- Machine-mode CSR file. Sits directly downstream of the MEM/WB pipeline register and consumes its CSR writeback (csr_wr_en/adder/data).
- Serves one combinational read port to the execute stage.
- Accepts a higher-priority write port from the trap/interrupt controller.
- Maintains the 64-bit mcycle and minstret counters and exports mtvec, mepc, mstatus and the global interrupt enable.

Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- MISA_VAL, 32'h4000_0100, read-only misa value (RV32I).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- csr_wr_en_i  in  1  writeback CSR write enable (from MEM/WB register)
- csr_wr_adder_i  in  `CSR_ADDR_WIDTH  writeback CSR address
- csr_wr_data_i  in  `CPU_WIDTH  writeback CSR data
- inst_retire_i  in  1  one instruction retires in WB this cycle
- trap_wr_en_i  in  1  trap controller write enable
- trap_wr_adder_i  in  `CSR_ADDR_WIDTH  trap controller address
- trap_wr_data_i  in  `CPU_WIDTH  trap controller data
- csr_rd_adder_i  in  `CSR_ADDR_WIDTH  execute-stage read address
- csr_rd_data_o  out  `CPU_WIDTH  read data (combinational)
- mtvec_o  out  `CPU_WIDTH  current mtvec
- mepc_o  out  `CPU_WIDTH  current mepc
- mstatus_o  out  `CPU_WIDTH  current mstatus
- global_int_en_o  out  1  mstatus.MIE

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - mtvec = MTVEC_RST
  - mstatus = 32'h0000_1800 (MPP = 2'b11, MIE = MPIE = 0)
  - mie, mscratch, mepc, mcause, mtval, mcycle, minstret = 0
  - Outputs reflect these values.
- Address map:
  - Read/write: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
  - Read-only: misa 0x301 (returns MISA_VAL); cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82 (aliases of the machine counters).
  - Unmapped addresses read 0. Writes to unmapped or read-only addresses are ignored.
- mstatus write mask: only bit 3 (MIE) and bit 7 (MPIE) are writable. Bits 12:11 are held at 2'b11; all other bits are 0.
- Writes are committed at the clock edge; the new value is visible on outputs the following cycle.
- Write priority:
  - If both ports write the same address in one cycle, the trap port wins.
  - If they write different addresses, both commit.
- Read port:
  - Fully combinational.
  - Forwarding: if csr_rd_adder_i matches an address being written this cycle (trap first, then WB), return the write data after the write mask. Read-only and unmapped addresses are never forwarded.
  - Otherwise return the register value. Counters return the pre-increment value.
- mcycle (64-bit) increments by 1 every cycle after reset deassertion.
  - A write to the low half replaces the low half; the high half still receives no increment that cycle.
  - A write to the high half replaces the high half; the low half still increments, and its carry is discarded that cycle.
  - Low half 32'hFFFF_FFFF increments to 0 and carries into the high half. Full 64-bit wrap goes to 0.
- minstret (64-bit) increments by 1 when inst_retire_i = 1, with the same write-overrides-increment and carry rules as mcycle.
- global_int_en_o = mstatus[3]. mtvec_o, mepc_o and mstatus_o are direct register outputs.
- Reset mid-operation clears all state immediately, including counters. No partial writes survive.

Decomposition:
- Shared defines header (existing): add the CSR address constants (CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH, CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH) and MSTATUS_WMASK = 32'h0000_0088.
- One natural sub-module: csr_counter64, a 64-bit incrementer with independent low/high write overrides. It is instantiated twice, for mcycle and minstret.

Test Plan:
- Reset released, hold 10 cycles, read 0xB00 -> 10; read 0xB80 -> 0; mstatus_o = 32'h0000_1800; mtvec_o = MTVEC_RST.
- WB write 0x300 with 32'hFFFF_FFFF -> next cycle mstatus_o = 32'h0000_1888 and global_int_en_o = 1. Same-cycle read of 0x300 -> 32'h0000_1888 (forwarded).
- WB write 0x341 = 32'h100 and trap write 0x341 = 32'h200 in the same cycle -> mepc_o = 32'h200. Then WB 0x305 = 32'h80 with trap 0x342 = 32'h8000_000B -> both committed.
- Write mcycle = 32'hFFFF_FFFE, mcycleh = 0 -> two cycles later read 0xB00 = 0 and 0xB80 = 1. Read of 0xC80 matches 0xB80.
- inst_retire_i high for 5 cycles, with a minstret write of 32'h10 during the 3rd -> read 0xB02 afterwards = 32'h12. Write to 0xC02 -> ignored. Read 0x7C0 -> 0.
- Assert rst_n low mid-stream, asynchronously between clock edges -> all outputs return to reset values immediately. Counters restart at 0 after release.
